// File: rtl/mmio_controller.sv
// mmio_controller: decodes button (1000), status (1001) and output (2000)
// addresses in front of the data RAM. Button presses are synchronized,
// optionally debounced and latched; processor output words are queued in a
// small FIFO drained by a valid/ready consumer.
// Build option: define MMIO_DEBOUNCE_EN to instantiate the debounce counter;
// without it the stable button level is the synchronizer output.
module mmio_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int OUT_DEPTH       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic        wren,
    input  logic [31:0] data,
    output logic [31:0] q_dmem,
    input  logic [31:0] ram_dataOut,
    output logic        ram_wEn,
    input  logic        button_raw,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int          PTR_W   = $clog2(OUT_DEPTH);
    localparam int          CNT_W   = $clog2(OUT_DEPTH + 1);
    localparam int unsigned DEPTH_U = OUT_DEPTH;

    localparam logic [31:0] ADDR_BTN  = 32'd1000;
    localparam logic [31:0] ADDR_STAT = 32'd1001;
    localparam logic [31:0] ADDR_OUT  = 32'd2000;

    if (DEBOUNCE_CYCLES < 1 || OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_cfg
        $error("mmio_controller: DEBOUNCE_CYCLES must be >= 1 and OUT_DEPTH a power of two >= 2");
    end

    logic hit_btn, hit_stat, hit_out;
    logic hit_btn_q, hit_stat_q, hit_out_q;
    logic strobe_btn, strobe_stat, push_req;

    logic              sync1, sync2, stable, stable_q, press;
    logic              pending, overflow;
    logic [7:0]        press_count;

    logic [31:0]       mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              fifo_full, pop, push_ok, push_drop;

    assign hit_btn  = (address_dmem == ADDR_BTN);
    assign hit_stat = (address_dmem == ADDR_STAT);
    assign hit_out  = (address_dmem == ADDR_OUT);
    assign ram_wEn  = wren & ~(hit_btn | hit_stat | hit_out);

    // An access strobe is the first cycle of a run on the same MMIO address.
    assign strobe_btn  = hit_btn & ~hit_btn_q & ~wren;
    assign strobe_stat = hit_stat & ~hit_stat_q & ~wren;
    assign push_req    = wren & hit_out & ~hit_out_q;

    assign fifo_full = (count == CNT_W'(OUT_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid & out_ready;
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign push_ok   = push_req & (~fifo_full | pop);
    assign push_drop = push_req & fifo_full & ~pop;

    // Read mux: MMIO registers or RAM pass-through, zero latency.
    always_comb begin
        q_dmem = ram_dataOut;
        if (hit_btn) begin
            q_dmem = {16'b0, press_count, 7'b0, pending};
        end else if (hit_stat) begin
            q_dmem = {29'b0, overflow, pending, fifo_full};
        end
    end

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button_raw;
            sync2 <= sync1;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [DB_W-1:0] db_cnt;
    logic            db_level;

    // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (!reset) begin
            db_cnt   <= '0;
            db_level <= 1'b0;
        end else if (sync2 == db_level) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= sync2;
            db_cnt   <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign stable = db_level;
`else
    assign stable = sync2;
`endif

    assign press = stable & ~stable_q;

    // Button latch, press counter, overflow flag and hit history.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stable_q    <= 1'b0;
            pending     <= 1'b0;
            press_count <= '0;
            overflow    <= 1'b0;
            hit_btn_q   <= 1'b0;
            hit_stat_q  <= 1'b0;
            hit_out_q   <= 1'b0;
        end else begin
            stable_q   <= stable;
            hit_btn_q  <= hit_btn;
            hit_stat_q <= hit_stat;
            hit_out_q  <= hit_out;
            if (press) begin
                pending     <= 1'b1;
                press_count <= press_count + 8'd1;
            end else if (strobe_btn) begin
                pending <= 1'b0;
            end
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (strobe_stat) begin
                overflow <= 1'b0;
            end
        end
    end

    // Output FIFO storage, pointers and occupancy.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH_U; i++) begin
                mem[PTR_W'(i)] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/mmio_controller.md
# mmio_controller

Memory-mapped I/O controller between the processor's data-memory port and the data RAM. It decodes the I/O addresses used by game software: button input at 1000, status at 1001, output at 2000. It debounces and latches button presses for the processor to read, and queues processor output words in a small FIFO drained by a valid/ready consumer such as a display or serial driver. All other addresses pass through to the RAM unchanged.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive stable synchronized samples required to accept a new button level (min 1).
- `OUT_DEPTH`, 4: output FIFO depth in words (power of two, ≥2).
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  one clock; reset is synchronous and active-low (0 = reset, sampled on rising `clock`).
- `address_dmem`  in  32  processor data address.
- `wren`  in  1  processor store enable.
- `data`  in  32  processor store data.
- `q_dmem`  out  32  read data returned to the processor.
- `ram_dataOut`  in  32  data RAM read data.
- `ram_wEn`  out  1  data RAM write enable.
- `button_raw`  in  1  asynchronous, bouncing button level (1 = pressed).
- `out_data`  out  32  FIFO head word.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- Address decode compares all 32 bits.
  - hit_btn: `address_dmem`==1000.
  - hit_stat: `address_dmem`==1001.
  - hit_out: `address_dmem`==2000.
  - `ram_wEn` = `wren` & no hit.
- Read mux (combinational):
  - hit_btn → {16'b0, press_count[7:0], 7'b0, pending}.
  - hit_stat → {29'b0, overflow, pending, fifo_full}.
  - otherwise `ram_dataOut`.
- Button path: 2-flop synchronizer, then debouncer.
  - Debouncer: counter resets whenever the synchronized bit equals the stable level. When it differs for DEBOUNCE_CYCLES consecutive cycles, the stable level takes the new value and the counter clears.
  - Stable 0→1 transition sets `pending` and increments `press_count` (8-bit, wraps 255→0).
- Read-clear uses the access strobe: hit this cycle & not hit last cycle (registered hit flags), with `wren`=0.
  - Strobe on hit_btn clears `pending`.
  - Strobe on hit_stat clears `overflow`.
  - If a new press is accepted in the same cycle as a clear, set wins: `pending` stays 1.
- Stores to 1000/1001 are ignored. No state changes and no RAM write.
- Output FIFO:
  - Push: `wren` & hit_out, once per strobe. A multi-cycle store pushes one word.
  - Pop: `out_valid` & `out_ready`.
  - Push while full with no pop: word dropped, `overflow` set (sticky until status read).
  - Push while full with pop in the same cycle: accepted, count unchanged.
- Reset (any cycle, including mid-store or mid-handshake) clears:
  - FIFO pointers/count → empty, so `out_valid`=0.
  - `pending`, `overflow`, `press_count`, stable level, debounce counter, synchronizer, hit history.

## Timing
- Reset values: `out_valid`=0, `out_data`=0 (FIFO storage zeroed), `ram_wEn`=`wren` & no hit (combinational), `q_dmem` combinational per the read mux.
- `q_dmem` has zero latency from `address_dmem`. The registered part of an MMIO read is status state as of the last edge.
- Push to an empty FIFO: `out_valid`=1 after the next rising edge. There is no bypass.
- Pop: head advances at the edge where `out_valid` & `out_ready`. `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.
- Button latency from a clean raw edge to `pending`=1: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles has no effect.

## Configuration
- `MMIO_DEBOUNCE_EN` defined: debounce counter instantiated as above.
- Not defined: stable level = synchronizer output directly. DEBOUNCE_CYCLES is ignored. Latency from raw edge to `pending` = 3 cycles.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `wren`=1 at addr 2000. Require `out_valid`=0, addr-1000 read=0, addr-1001 read=0 after release.
- Debounce (`MMIO_DEBOUNCE_EN`, DEBOUNCE_CYCLES=16):
  - Toggle `button_raw` 1/0 every 3 cycles for 30 cycles: `pending` stays 0.
  - Then hold 1: `pending`=1 at cycle 19, addr-1000 read=0x101.
  - Second access strobe to 1000 reads 0x100.
- Output queue: store 0xA, 0xB, 0xC, 0xD, 0xE to 2000 with `out_ready`=0.
  - First four are queued; 0xE is dropped. Status read=0b101 then 0b001.
  - Raise `out_ready`: drains A,B,C,D in order, one per cycle.
- Full simultaneous: with FIFO full and `out_ready`=1, store 0x55. Require no overflow and 0x55 emerges fifth.
- Pass-through: store 0x1234 to addr 5 → `ram_wEn`=1. Store to 1000 → `ram_wEn`=0. Read addr 5 returns `ram_dataOut`.
- Set beats clear: accepted press coincides with a 1000 access strobe → `pending` remains 1 and `press_count` increments.
